sys_ctrl_cmd: RTL and testbench
===============================

# sys_ctrl_cmd

Command controller between the UART receive path and the register file/ALU. It parses byte-serial commands from the RX deserializer and turns them into register-file write/read strobes and ALU operations. Responses (read data, ALU results) go byte-wise into the TX FIFO. It is the only master of the register-file write/read port and the ALU enable.

## Interface
- Data, 8, byte/register width
- Addr, 3, register-file address width
- FunW, 4, ALU function-code width
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  Data  received byte
- RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid
- RdData  in  Data  register-file read data
- RdData_Valid  in  1  register-file read data valid
- ALU_OUT  in  2*Data  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full; no push allowed
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  Addr  register-file address
- WrData  out  Data  register-file write data
- ALU_EN  out  1  ALU operation enable
- ALU_FUN  out  FunW  ALU function code
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  Data  byte pushed to TX FIFO
- TX_D_VLD  out  1  one-cycle TX FIFO push strobe

## Operation
- Command bytes (first byte in IDLE):
  - 0xAA: register write. Sequence is address byte, then data byte.
  - 0xBB: register read. Sequence is address byte.
  - 0xCC: ALU with operands. Sequence is operand A, operand B, then function byte.
  - 0xDD: ALU without operands. Sequence is function byte.
  - Any other byte in IDLE is discarded and the block stays in IDLE.
- Address byte: bits [Addr-1:0] are used and the upper bits are ignored. The function byte uses bits [FunW-1:0].
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB.
  - IDLE goes to WR_ADDR, RD_ADDR, OP_A or ALU_FN on 0xAA, 0xBB, 0xCC or 0xDD.
  - WR_ADDR goes to WR_DATA on the next byte (address latched). WR_DATA goes to IDLE on the next byte; WrEn pulses.
  - RD_ADDR goes to RD_WAIT on the next byte; RdEn pulses. RD_WAIT goes to TX_RD on RdData_Valid (RdData captured). TX_RD goes to IDLE after the push.
  - OP_A goes to OP_B on the next byte: WrEn pulses with Address=0 and WrData=byte. OP_B goes to ALU_FN on the next byte: WrEn pulses with Address=1.
  - ALU_FN goes to ALU_WAIT on the next byte: ALU_FUN latched, ALU_EN and CLK_EN set.
  - ALU_WAIT goes to TX_LSB on ALU_OUT_VLD: result captured, ALU_EN and CLK_EN cleared.
  - TX_LSB goes to TX_MSB after pushing ALU_OUT[Data-1:0]. TX_MSB goes to IDLE after pushing ALU_OUT[2*Data-1:Data].
- Push rule in TX states: TX_D_VLD=1 only when FIFO_FULL=0. While FIFO_FULL=1 the block holds its state with TX_D_VLD=0. Each byte is pushed exactly once.
- WrEn and RdEn are never high together and each is never high for two consecutive cycles.
- RX_D_VLD in RD_WAIT, ALU_WAIT or any TX state: the byte is dropped and has no effect.
- No timeout. The block waits indefinitely in RD_WAIT and ALU_WAIT.

## Timing
- All outputs are registered.
- Reset values: every output is 0, the state is IDLE and the capture registers are 0.
- Reset at any point aborts the command and returns to IDLE in the same cycle. No strobe is emitted after RST rises.
- Register write: WrEn=1 with Address/WrData valid in the cycle after the RX_D_VLD of the data byte, for exactly 1 cycle.
- Register read: RdEn=1 for 1 cycle after the address byte's RX_D_VLD. RdData is captured on the cycle RdData_Valid=1. The TX push happens at the earliest the next cycle.
- ALU: ALU_EN, CLK_EN and ALU_FUN go valid in the cycle after the function byte. They hold until the cycle after ALU_OUT_VLD is sampled high, then drop to 0.
- Result pushes are LSB then MSB, in consecutive cycles if FIFO_FULL=0. With no stall, TX_LSB and TX_MSB take 1 cycle each.
- Back-to-back commands: a new command byte is accepted in IDLE on the cycle immediately after the previous command completes.

## Test plan
- Write: bytes AA, 05, 3C → WrEn=1 for one cycle with Address=5, WrData=0x3C; no TX push.
- Read-back: after the write above, bytes BB, 05 → RdEn pulse with Address=5; the bench register model returns 0x3C → TX_D_VLD once with TX_P_DATA=0x3C.
- ALU with operands: bytes CC, 0A, 03, 00 → WrEn pulses at Address 0 (0x0A) and Address 1 (0x03). Then ALU_EN=1, CLK_EN=1, ALU_FUN=0. The ALU model returns 0x000D → pushes 0x0D then 0x00.
- FIFO backpressure: during a DD, 02 result with ALU_OUT=0x1234, hold FIFO_FULL=1 for 5 cycles → no push during the stall. After release: 0x34 then 0x12, each exactly once.
- Robustness: byte 0x55 in IDLE is ignored. An RX byte during ALU_WAIT is dropped. Assert RST in WR_DATA before the data byte → all outputs 0, state IDLE, and no WrEn after release.

Source files
------------

// File: rtl/sys_ctrl_cmd_if.sv
// Bus between the command controller and its surroundings: RX bytes in,
// register-file/ALU control out, and the TX FIFO push port.
interface sys_ctrl_cmd_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int FUN_W  = 4
);
  logic [DATA_W-1:0]   RX_P_DATA;
  logic                RX_D_VLD;
  logic [DATA_W-1:0]   RdData;
  logic                RdData_Valid;
  logic [2*DATA_W-1:0] ALU_OUT;
  logic                ALU_OUT_VLD;
  logic                FIFO_FULL;

  logic                WrEn;
  logic                RdEn;
  logic [ADDR_W-1:0]   Address;
  logic [DATA_W-1:0]   WrData;
  logic                ALU_EN;
  logic [FUN_W-1:0]    ALU_FUN;
  logic                CLK_EN;
  logic [DATA_W-1:0]   TX_P_DATA;
  logic                TX_D_VLD;

  // Controller view.
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

  // Environment view: RX deserializer, register file, ALU and TX FIFO.
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_ctrl_cmd.sv
// Byte-serial command parser: drives register-file write/read strobes and the
// ALU, and returns read data / ALU results byte-wise to the TX FIFO.
module sys_ctrl_cmd #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int FUN_W  = 4
) (
  input  logic           CLK,
  input  logic           RST,
  sys_ctrl_cmd_if.master bus
);

  localparam logic [DATA_W-1:0] CMD_WR     = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD     = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU_OP = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_ALU_NO = DATA_W'(8'hDD);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] WR_ADDR  = 4'd1;
  localparam logic [3:0] WR_DATA  = 4'd2;
  localparam logic [3:0] RD_ADDR  = 4'd3;
  localparam logic [3:0] RD_WAIT  = 4'd4;
  localparam logic [3:0] OP_A     = 4'd5;
  localparam logic [3:0] OP_B     = 4'd6;
  localparam logic [3:0] ALU_FN   = 4'd7;
  localparam logic [3:0] ALU_WAIT = 4'd8;
  localparam logic [3:0] TX_RD    = 4'd9;
  localparam logic [3:0] TX_LSB   = 4'd10;
  localparam logic [3:0] TX_MSB   = 4'd11;

  logic [3:0]          state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wrdata_q,  wrdata_d;
  logic                wren_q,    wren_d;
  logic                rden_q,    rden_d;
  logic                alu_en_q,  alu_en_d;
  logic                clk_en_q,  clk_en_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_vld_q,  tx_vld_d;
  logic [DATA_W-1:0]   rd_cap_q,  rd_cap_d;
  logic [2*DATA_W-1:0] res_q,     res_d;

  logic              rx_vld;
  logic [DATA_W-1:0] rx_byte;
  logic              tx_ok;

  assign rx_vld  = bus.RX_D_VLD;
  assign rx_byte = bus.RX_P_DATA;
  assign tx_ok   = !bus.FIFO_FULL;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    alu_en_d  = alu_en_q;
    clk_en_d  = clk_en_q;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    rd_cap_d  = rd_cap_q;
    res_d     = res_q;

    case (state_q)
      IDLE: begin
        if (rx_vld) begin
          case (rx_byte)
            CMD_WR:     state_d = WR_ADDR;
            CMD_RD:     state_d = RD_ADDR;
            CMD_ALU_OP: state_d = OP_A;
            CMD_ALU_NO: state_d = ALU_FN;
            default:    state_d = IDLE;
          endcase
        end
      end

      WR_ADDR: begin
        if (rx_vld) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (rx_vld) begin
          wrdata_d = rx_byte;
          wren_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      RD_ADDR: begin
        if (rx_vld) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          rden_d  = 1'b1;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          rd_cap_d = bus.RdData;
          state_d  = TX_RD;
        end
      end

      OP_A: begin
        if (rx_vld) begin
          addr_d   = '0;
          wrdata_d = rx_byte;
          wren_d   = 1'b1;
          state_d  = OP_B;
        end
      end

      // Operand B arriving right behind A would make WrEn high twice in a row;
      // such a byte is not accepted.
      OP_B: begin
        if (rx_vld && !wren_q) begin
          addr_d   = ADDR_W'(1);
          wrdata_d = rx_byte;
          wren_d   = 1'b1;
          state_d  = ALU_FN;
        end
      end

      ALU_FN: begin
        if (rx_vld) begin
          alu_fun_d = rx_byte[FUN_W-1:0];
          alu_en_d  = 1'b1;
          clk_en_d  = 1'b1;
          state_d   = ALU_WAIT;
        end
      end

      ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          res_d     = bus.ALU_OUT;
          alu_en_d  = 1'b0;
          clk_en_d  = 1'b0;
          alu_fun_d = '0;
          state_d   = TX_LSB;
        end
      end

      TX_RD: begin
        if (tx_ok) begin
          tx_data_d = rd_cap_q;
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      TX_LSB: begin
        if (tx_ok) begin
          tx_data_d = res_q[DATA_W-1:0];
          tx_vld_d  = 1'b1;
          state_d   = TX_MSB;
        end
      end

      TX_MSB: begin
        if (tx_ok) begin
          tx_data_d = res_q[2*DATA_W-1:DATA_W];
          tx_vld_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      alu_fun_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rd_cap_q  <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      alu_fun_q <= alu_fun_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      rd_cap_q  <= rd_cap_d;
      res_q     <= res_d;
    end
  end

  assign bus.WrEn      = wren_q;
  assign bus.RdEn      = rden_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wrdata_q;
  assign bus.ALU_EN    = alu_en_q;
  assign bus.ALU_FUN   = alu_fun_q;
  assign bus.CLK_EN    = clk_en_q;
  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_sys_ctrl_cmd.sv
// Scenario bench for sys_ctrl_cmd with a register-file model, an ALU model and
// a monitor that logs every strobe/push for scoreboard comparison.
module tb_sys_ctrl_cmd;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int FUN_W  = 4;

  logic CLK = 1'b0;
  logic RST;

  sys_ctrl_cmd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) bus ();

  sys_ctrl_cmd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Register-file model: one-cycle read latency.
  logic [7:0] regs [8];
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      bus.RdData       <= 8'h00;
      bus.RdData_Valid <= 1'b0;
    end else begin
      if (bus.WrEn) regs[bus.Address] <= bus.WrData;
      bus.RdData_Valid <= bus.RdEn;
      if (bus.RdEn) bus.RdData <= regs[bus.Address];
    end
  end

  // ALU model: result alu_lat+1 cycles after ALU_EN, one VLD pulse per enable.
  int          alu_lat      = 2;
  logic        alu_force_en = 1'b0;
  logic [15:0] alu_force    = 16'h0000;
  int          alu_cnt;
  logic        alu_done;

  function automatic logic [15:0] alu_calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_cnt         <= 0;
      alu_done        <= 1'b0;
      bus.ALU_OUT_VLD <= 1'b0;
      bus.ALU_OUT     <= 16'h0000;
    end else begin
      bus.ALU_OUT_VLD <= 1'b0;
      if (!bus.ALU_EN) begin
        alu_done <= 1'b0;
        alu_cnt  <= 0;
      end else if (!alu_done) begin
        if (alu_cnt >= alu_lat) begin
          bus.ALU_OUT_VLD <= 1'b1;
          bus.ALU_OUT     <= alu_force_en ? alu_force : alu_calc(bus.ALU_FUN, regs[0], regs[1]);
          alu_done        <= 1'b1;
        end else begin
          alu_cnt <= alu_cnt + 1;
        end
      end
    end
  end

  // Monitor: log strobes and pushes on the falling edge.
  logic [10:0] obs_wr [$];
  logic [2:0]  obs_rd [$];
  logic [7:0]  obs_tx [$];
  int          obs_tx_cyc [$];
  int          cyc     = 0;
  int          viol    = 0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (bus.WrEn) obs_wr.push_back({bus.Address, bus.WrData});
    if (bus.RdEn) obs_rd.push_back(bus.Address);
    if (bus.TX_D_VLD) begin
      obs_tx.push_back(bus.TX_P_DATA);
      obs_tx_cyc.push_back(cyc);
    end
    if ((bus.WrEn && bus.RdEn) || (bus.WrEn && prev_wr) || (bus.RdEn && prev_rd))
      viol <= viol + 1;
    prev_wr <= bus.WrEn;
    prev_rd <= bus.RdEn;
  end

  logic [10:0] exp_wr [$];
  logic [2:0]  exp_rd [$];
  logic [7:0]  exp_tx [$];

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic wait_tx(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_tx.size() >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic clear_exp();
    exp_wr.delete();
    exp_rd.delete();
    exp_tx.delete();
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    RST = 1'b0;
    idle(3);
    outs = {bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
            bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD};
    vectors++;
    if (outs !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    vectors++;
    if (dut.state_q !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected 0", dut.state_q);
    end
    RST = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    int w0 = obs_wr.size();
    int t0 = obs_tx.size();
    logic [10:0] e;
    clear_exp();
    exp_wr.push_back({3'd5, 8'h3C});
    send_byte(8'hAA); idle(2);
    send_byte(8'h05); idle(2);
    send_byte(8'h3C); idle(4);
    vectors++;
    if (obs_wr.size() - w0 !== exp_wr.size()) begin
      miscompares++;
      $display("FAIL write_count: got %0d expected %0d", obs_wr.size() - w0, exp_wr.size());
    end else begin
      e = exp_wr.pop_front();
      vectors++;
      if (obs_wr[w0] !== e) begin
        miscompares++;
        $display("FAIL write_addr_data: got %h expected %h", obs_wr[w0], e);
      end
    end
    vectors++;
    if (obs_tx.size() !== t0) begin
      miscompares++;
      $display("FAIL write_no_tx: got %0d pushes expected 0", obs_tx.size() - t0);
    end
  endtask

  task automatic test_read();
    int r0 = obs_rd.size();
    int t0 = obs_tx.size();
    bit ok;
    logic [7:0] e;
    clear_exp();
    exp_rd.push_back(3'd5);
    exp_tx.push_back(8'h3C);
    send_byte(8'hBB); idle(2);
    send_byte(8'h05);
    wait_tx(t0 + 1, 30, ok);
    idle(4);
    vectors++;
    if (!ok || obs_tx.size() - t0 !== 1) begin
      miscompares++;
      $display("FAIL read_tx_count: got %0d expected 1", obs_tx.size() - t0);
    end else begin
      e = exp_tx.pop_front();
      vectors++;
      if (obs_tx[t0] !== e) begin
        miscompares++;
        $display("FAIL read_tx_data: got %h expected %h", obs_tx[t0], e);
      end
    end
    vectors++;
    if (obs_rd.size() - r0 !== 1 || obs_rd[r0] !== exp_rd[0]) begin
      miscompares++;
      $display("FAIL read_strobe: got %0d strobes expected 1 at addr %0d", obs_rd.size() - r0, exp_rd[0]);
    end
  endtask

  task automatic test_alu_ops();
    int w0 = obs_wr.size();
    int t0 = obs_tx.size();
    bit ok;
    clear_exp();
    exp_wr.push_back({3'd0, 8'h0A});
    exp_wr.push_back({3'd1, 8'h03});
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h00);
    send_byte(8'hCC); idle(2);
    send_byte(8'h0A); idle(2);
    send_byte(8'h03); idle(2);
    send_byte(8'h00);
    vectors++;
    if ({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN} !== 6'b11_0000) begin
      miscompares++;
      $display("FAIL alu_enable: got %b expected 110000", {bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN});
    end
    wait_tx(t0 + 2, 40, ok);
    idle(4);
    vectors++;
    if (obs_wr.size() - w0 !== 2) begin
      miscompares++;
      $display("FAIL alu_opwr_count: got %0d expected 2", obs_wr.size() - w0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_wr[w0 + i] !== exp_wr[i]) begin
          miscompares++;
          $display("FAIL alu_opwr_%0d: got %h expected %h", i, obs_wr[w0 + i], exp_wr[i]);
        end
      end
    end
    vectors++;
    if (!ok || obs_tx.size() - t0 !== 2) begin
      miscompares++;
      $display("FAIL alu_tx_count: got %0d expected 2", obs_tx.size() - t0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_tx[t0 + i] !== exp_tx[i]) begin
          miscompares++;
          $display("FAIL alu_tx_%0d: got %h expected %h", i, obs_tx[t0 + i], exp_tx[i]);
        end
      end
      vectors++;
      if (obs_tx_cyc[t0 + 1] - obs_tx_cyc[t0] !== 1) begin
        miscompares++;
        $display("FAIL alu_tx_gap: got %0d cycles expected 1", obs_tx_cyc[t0 + 1] - obs_tx_cyc[t0]);
      end
    end
    vectors++;
    if ({bus.ALU_EN, bus.CLK_EN} !== 2'b00) begin
      miscompares++;
      $display("FAIL alu_release: got %b expected 00", {bus.ALU_EN, bus.CLK_EN});
    end
  endtask

  task automatic test_backpressure();
    int t0 = obs_tx.size();
    bit ok;
    bit dropped = 1'b0;
    clear_exp();
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    alu_force_en = 1'b1;
    alu_force    = 16'h1234;
    bus.FIFO_FULL = 1'b1;
    send_byte(8'hDD); idle(2);
    send_byte(8'h02);
    vectors++;
    if (bus.ALU_FUN !== 4'd2) begin
      miscompares++;
      $display("FAIL bp_alu_fun: got %0d expected 2", bus.ALU_FUN);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (!bus.ALU_EN) begin
        dropped = 1'b1;
        break;
      end
    end
    vectors++;
    if (!dropped) begin
      miscompares++;
      $display("FAIL bp_alu_done: got ALU_EN=%b expected 0", bus.ALU_EN);
    end
    idle(5);
    vectors++;
    if (obs_tx.size() !== t0) begin
      miscompares++;
      $display("FAIL bp_stall_push: got %0d pushes expected 0", obs_tx.size() - t0);
    end
    bus.FIFO_FULL = 1'b0;
    wait_tx(t0 + 2, 20, ok);
    idle(5);
    vectors++;
    if (!ok || obs_tx.size() - t0 !== 2) begin
      miscompares++;
      $display("FAIL bp_tx_count: got %0d expected 2", obs_tx.size() - t0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_tx[t0 + i] !== exp_tx[i]) begin
          miscompares++;
          $display("FAIL bp_tx_%0d: got %h expected %h", i, obs_tx[t0 + i], exp_tx[i]);
        end
      end
    end
    alu_force_en = 1'b0;
  endtask

  task automatic test_robust();
    int w0 = obs_wr.size();
    int r0 = obs_rd.size();
    int t0 = obs_tx.size();
    bit ok;
    logic [27:0] outs;
    clear_exp();
    send_byte(8'h55); idle(3);
    vectors++;
    if (dut.state_q !== 4'd0 || obs_wr.size() !== w0 || obs_rd.size() !== r0 || obs_tx.size() !== t0) begin
      miscompares++;
      $display("FAIL junk_byte: got state %0d wr %0d rd %0d tx %0d expected idle and no activity",
               dut.state_q, obs_wr.size() - w0, obs_rd.size() - r0, obs_tx.size() - t0);
    end

    // Bytes arriving during ALU_WAIT must be dropped.
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'h0A);
    alu_lat = 10;
    send_byte(8'hDD); idle(1);
    send_byte(8'h03); idle(3);
    send_byte(8'hAA); idle(2);
    send_byte(8'h01);
    wait_tx(t0 + 2, 60, ok);
    idle(4);
    alu_lat = 2;
    vectors++;
    if (!ok || obs_tx.size() - t0 !== 2) begin
      miscompares++;
      $display("FAIL drop_tx_count: got %0d expected 2", obs_tx.size() - t0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs_tx[t0 + i] !== exp_tx[i]) begin
          miscompares++;
          $display("FAIL drop_tx_%0d: got %h expected %h", i, obs_tx[t0 + i], exp_tx[i]);
        end
      end
    end
    vectors++;
    if (obs_wr.size() !== w0 || dut.state_q !== 4'd0) begin
      miscompares++;
      $display("FAIL drop_effect: got wr %0d state %0d expected 0 and 0", obs_wr.size() - w0, dut.state_q);
    end

    // Reset while waiting for the write data byte.
    send_byte(8'hAA); idle(1);
    send_byte(8'h06); idle(1);
    vectors++;
    if (dut.state_q !== 4'd2) begin
      miscompares++;
      $display("FAIL rst_precond: got state %0d expected 2", dut.state_q);
    end
    RST = 1'b0;
    #1;
    outs = {bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN, bus.ALU_FUN,
            bus.CLK_EN, bus.TX_P_DATA, bus.TX_D_VLD};
    vectors++;
    if (outs !== 28'h0 || dut.state_q !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_abort: got outs %h state %0d expected 0 and 0", outs, dut.state_q);
    end
    idle(2);
    RST = 1'b1;
    idle(1);
    send_byte(8'h77); idle(4);
    vectors++;
    if (obs_wr.size() !== w0 || dut.state_q !== 4'd0) begin
      miscompares++;
      $display("FAIL rst_no_wren: got wr %0d state %0d expected 0 and 0", obs_wr.size() - w0, dut.state_q);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = obs_wr.size();
    int r0 = obs_rd.size();
    int t0 = obs_tx.size();
    bit ok;
    clear_exp();
    exp_wr.push_back({3'd2, 8'h55});
    exp_rd.push_back(3'd2);
    exp_tx.push_back(8'h55);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h55);
    send_byte(8'hBB);
    send_byte(8'h02);
    wait_tx(t0 + 1, 30, ok);
    idle(4);
    vectors++;
    if (obs_wr.size() - w0 !== 1 || obs_wr[w0] !== exp_wr[0]) begin
      miscompares++;
      $display("FAIL b2b_write: got %0d writes first %h expected 1 of %h", obs_wr.size() - w0, obs_wr[w0], exp_wr[0]);
    end
    vectors++;
    if (obs_rd.size() - r0 !== 1 || obs_rd[r0] !== exp_rd[0]) begin
      miscompares++;
      $display("FAIL b2b_read: got %0d reads expected 1 at addr %0d", obs_rd.size() - r0, exp_rd[0]);
    end
    vectors++;
    if (!ok || obs_tx.size() - t0 !== 1 || obs_tx[t0] !== exp_tx[0]) begin
      miscompares++;
      $display("FAIL b2b_tx: got %0d pushes first %h expected 1 of %h", obs_tx.size() - t0, obs_tx[t0], exp_tx[0]);
    end
    vectors++;
    if (viol !== 0) begin
      miscompares++;
      $display("FAIL strobe_rules: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.FIFO_FULL = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_backpressure();
    test_robust();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
